// File: rtl/plru_repl_ctrl_pkg.sv
// Shared types and helper functions for the tree pseudo-LRU replacement controller.
// The tree functions work on a maximum-size tree (16 ways, 15 node bits). The real way
// count is passed as an argument, so one package serves every NWAYS from 2 to 16.
package plru_repl_ctrl_pkg;

   localparam int MAX_WAYS   = 16;
   localparam int MAX_LEVELS = 4;

   typedef logic [MAX_WAYS-2:0] plru_tree_t;
   typedef logic [MAX_WAYS-1:0] way_mask_t;
   typedef logic [3:0]          way_idx_t;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } plru_state_e;

   // Ceiling log2. Returns 1 for n=2.
   function automatic int log2x(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Pick a victim. The lowest unlocked invalid way wins if there is one.
   // Otherwise walk the tree from the root. At each node, steer away from a subtree
   // whose ways are all locked. If both subtrees are locked, follow the tree bit.
   function automatic way_idx_t plru_victim(input plru_tree_t tree, input way_mask_t valid,
                                            input way_mask_t lock, input int nways);
      int       lo;
      int       size;
      int       half;
      int       node;
      int       levels;
      logic     found;
      logic     l_all;
      logic     r_all;
      logic     dir;
      way_idx_t way;
      levels = log2x(nways);
      found  = 1'b0;
      way    = '0;
      for (int i = 0; i < MAX_WAYS; i++) begin
         if (!found && (i < nways) && !valid[i[3:0]] && !lock[i[3:0]]) begin
            found = 1'b1;
            way   = way_idx_t'(i);
         end
      end
      if (!found) begin
         lo   = 0;
         size = nways;
         node = 0;
         for (int l = 0; l < MAX_LEVELS; l++) begin
            if (l < levels) begin
               half  = size / 2;
               l_all = 1'b1;
               r_all = 1'b1;
               for (int i = 0; i < MAX_WAYS; i++) begin
                  if ((i >= lo) && (i < lo + half) && !lock[i[3:0]]) l_all = 1'b0;
                  if ((i >= lo + half) && (i < lo + size) && !lock[i[3:0]]) r_all = 1'b0;
               end
               if (l_all && !r_all)      dir = 1'b1;
               else if (r_all && !l_all) dir = 1'b0;
               else                      dir = tree[node[3:0]];
               if (dir) lo = lo + half;
               node = 2 * node + 1 + int'(dir);
               size = half;
            end
         end
         way = way_idx_t'(lo);
      end
      return way;
   endfunction

   // Make every node on the path to 'way' point away from it.
   function automatic plru_tree_t plru_update(input plru_tree_t tree, input way_idx_t way,
                                              input int nways);
      plru_tree_t t;
      int         node;
      int         levels;
      int         idx;
      logic       dir;
      t      = tree;
      node   = 0;
      levels = log2x(nways);
      for (int l = 0; l < MAX_LEVELS; l++) begin
         if (l < levels) begin
            idx            = levels - 1 - l;
            dir            = way[idx[1:0]];
            t[node[3:0]]   = ~dir;
            node           = 2 * node + 1 + int'(dir);
         end
      end
      return t;
   endfunction

endpackage

// File: rtl/plru_repl_ctrl_if.sv
// Request/response bundle of the pseudo-LRU replacement controller.
// With PLRU_LOCK_EN defined it also carries lock_mask and resp_all_locked.
// Handshake: a request is taken in any cycle where req_valid && req_ready.
// There is no response backpressure. resp_valid pulses for one cycle, one cycle after acceptance.
interface plru_repl_ctrl_if #(
   parameter int NWAYS = 4,
   parameter int NSETS = 64
);
   import plru_repl_ctrl_pkg::*;

   localparam int WAYBITS = log2x(NWAYS);
   localparam int SETBITS = log2x(NSETS);

   logic               req_valid;
   logic               req_ready;
   logic [SETBITS-1:0] req_set;
   logic               req_hit;
   logic [WAYBITS-1:0] req_hit_way;
   logic [NWAYS-1:0]   req_valid_mask;
   logic               resp_valid;
   logic [SETBITS-1:0] resp_set;
   logic [WAYBITS-1:0] resp_way;
   logic               init_done;
`ifdef PLRU_LOCK_EN
   logic [NWAYS-1:0]   lock_mask;
   logic               resp_all_locked;

   modport master (output req_valid, req_set, req_hit, req_hit_way, req_valid_mask, lock_mask,
                   input  req_ready, resp_valid, resp_set, resp_way, resp_all_locked, init_done);
   modport slave  (input  req_valid, req_set, req_hit, req_hit_way, req_valid_mask, lock_mask,
                   output req_ready, resp_valid, resp_set, resp_way, resp_all_locked, init_done);
`else
   modport master (output req_valid, req_set, req_hit, req_hit_way, req_valid_mask,
                   input  req_ready, resp_valid, resp_set, resp_way, init_done);
   modport slave  (input  req_valid, req_set, req_hit, req_hit_way, req_valid_mask,
                   output req_ready, resp_valid, resp_set, resp_way, init_done);
`endif

endinterface

// File: rtl/plru_repl_ctrl_state_ram.sv
// Per-set tree storage: NSETS x TREEBITS, one async read port and one sync write port.
// The array has no reset. The controller's INIT sweep clears it.
module plru_state_ram #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 3,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Synchronous write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/plru_repl_ctrl.sv
// Tree pseudo-LRU replacement controller, one tree per cache set.
// S0 reads the set's tree (forwarded from S1 on a same-set collision) and picks the way.
// S1 holds the response and writes the new tree back at the end of its cycle.
// Optional locking is enabled by the PLRU_LOCK_EN macro.
module plru_repl_ctrl
   import plru_repl_ctrl_pkg::*;
#(
   parameter int NWAYS = 4,
   parameter int NSETS = 64
) (
   input  logic            gclk,
   input  logic            rst,
   plru_repl_ctrl_if.slave bus,
   output plru_state_e     dbg_state
);

   localparam int WAYBITS  = log2x(NWAYS);
   localparam int SETBITS  = log2x(NSETS);
   localparam int TREEBITS = NWAYS - 1;

   plru_state_e         state_q, state_d;
   logic [SETBITS-1:0]  ptr_q, ptr_d;

   logic                resp_valid_q, resp_valid_d;
   logic [SETBITS-1:0]  resp_set_q, resp_set_d;
   logic [WAYBITS-1:0]  resp_way_q, resp_way_d;
   logic [TREEBITS-1:0] tree_q, tree_d;

   logic                accept;
   logic [TREEBITS-1:0] rd_tree;
   logic [TREEBITS-1:0] cur_tree;
   logic [TREEBITS-1:0] new_tree;
   plru_tree_t          upd_tree;
   way_idx_t            victim;
   logic [WAYBITS-1:0]  sel_way;
   way_mask_t           lock_ext;
   logic                all_locked;
   logic                skip_upd;

   logic                wr_en;
   logic [SETBITS-1:0]  wr_addr;
   logic [TREEBITS-1:0] wr_data;

`ifdef PLRU_LOCK_EN
   logic                all_locked_q, all_locked_d;
   assign lock_ext   = way_mask_t'(bus.lock_mask);
   assign all_locked = &bus.lock_mask;
   assign bus.resp_all_locked = all_locked_q;
`else
   assign lock_ext   = '0;
   assign all_locked = 1'b0;
`endif

   assign accept         = bus.req_valid && (state_q == ST_RUN);
   assign bus.req_ready  = (state_q == ST_RUN);
   assign bus.init_done  = (state_q == ST_RUN);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_set   = resp_set_q;
   assign bus.resp_way   = resp_way_q;
   assign dbg_state      = state_q;

   // FSM next state: the INIT sweep clears one set per cycle, then stays in RUN
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == ST_INIT) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == SETBITS'(NSETS - 1)) begin
            state_d = ST_RUN;
            ptr_d   = '0;
         end
      end
   end

   // FSM and sweep pointer registers
   always_ff @(posedge gclk or posedge rst) begin
      if (rst) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // S0: use S1's new tree for a same-set request, then pick the way and compute the new tree
   always_comb begin
      cur_tree = rd_tree;
      if (resp_valid_q && (resp_set_q == bus.req_set)) cur_tree = tree_q;
      victim   = plru_victim(plru_tree_t'(cur_tree), way_mask_t'(bus.req_valid_mask), lock_ext, NWAYS);
      sel_way  = bus.req_hit ? bus.req_hit_way : WAYBITS'(victim);
      upd_tree = plru_update(plru_tree_t'(cur_tree), way_idx_t'(sel_way), NWAYS);
      skip_upd = !bus.req_hit && all_locked;
      new_tree = skip_upd ? cur_tree : upd_tree[TREEBITS-1:0];
   end

   // S1 next values: capture on acceptance, hold otherwise
   always_comb begin
      resp_valid_d = accept;
      resp_set_d   = resp_set_q;
      resp_way_d   = resp_way_q;
      tree_d       = tree_q;
`ifdef PLRU_LOCK_EN
      all_locked_d = all_locked_q;
`endif
      if (accept) begin
         resp_set_d   = bus.req_set;
         resp_way_d   = sel_way;
         tree_d       = new_tree;
`ifdef PLRU_LOCK_EN
         all_locked_d = skip_upd;
`endif
      end
   end

   // S1 register; reset drops any in-flight response
   always_ff @(posedge gclk or posedge rst) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_set_q   <= '0;
         resp_way_q   <= '0;
         tree_q       <= '0;
`ifdef PLRU_LOCK_EN
         all_locked_q <= 1'b0;
`endif
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_set_q   <= resp_set_d;
         resp_way_q   <= resp_way_d;
         tree_q       <= tree_d;
`ifdef PLRU_LOCK_EN
         all_locked_q <= all_locked_d;
`endif
      end
   end

   // Write port: INIT sweep clears, otherwise S1 commits its tree. An all-locked miss
   // carries the unmodified tree, so its commit leaves the stored value the same.
   always_comb begin
      wr_en   = resp_valid_q;
      wr_addr = resp_set_q;
      wr_data = tree_q;
      if (state_q == ST_INIT) begin
         wr_en   = 1'b1;
         wr_addr = ptr_q;
         wr_data = '0;
      end
   end

   plru_state_ram #(
      .DEPTH (NSETS),
      .WIDTH (TREEBITS),
      .AW    (SETBITS)
   ) u_state_ram (
      .clk   (gclk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (bus.req_set),
      .rdata (rd_tree)
   );

endmodule
